// File: rtl/switch_operand_loader.sv
// switch_operand_loader: synchronises switches and load button, debounces the button,
// and captures A/B/OpCode fields once per clean press with a one-cycle strobe.
module switch_operand_loader #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_WIDTH       = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] switches,
    input  logic        btn_load,
    output logic [7:0]  reg_a,
    output logic [7:0]  reg_b,
    output logic [7:0]  reg_op,
    output logic        load_strobe,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [23:0]           sw_meta_q, switches_s;
    logic                  btn_meta_q, btn_s;
    logic [7:0]            reg_a_q, reg_b_q, reg_op_q;
    logic                  strobe_q, capture;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta_q  <= '0;
            switches_s <= '0;
            btn_meta_q <= 1'b0;
            btn_s      <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            reg_a_q    <= '0;
            reg_b_q    <= '0;
            reg_op_q   <= '0;
            strobe_q   <= 1'b0;
        end else begin
            sw_meta_q  <= switches;
            switches_s <= sw_meta_q;
            btn_meta_q <= btn_load;
            btn_s      <= btn_meta_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            strobe_q   <= capture;
            if (capture) begin
                reg_a_q  <= switches_s[7:0];
                reg_b_q  <= switches_s[15:8];
                reg_op_q <= switches_s[23:16];
            end
        end
    end
    // Counter restarts on every transition, so it only measures the current WAIT dwell.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:         state_d = btn_s ? PRESS_WAIT : IDLE;
            PRESS_WAIT:   state_d = !btn_s ? IDLE : (cnt_q == LAST) ? HELD : PRESS_WAIT;
            HELD:         state_d = btn_s ? HELD : RELEASE_WAIT;
            RELEASE_WAIT: state_d = btn_s ? HELD : (cnt_q == LAST) ? IDLE : RELEASE_WAIT;
            default:      state_d = IDLE;
        endcase
        cnt_d = (state_d != state_q) ? '0
              : (state_q == PRESS_WAIT || state_q == RELEASE_WAIT) ? cnt_q + CNT_WIDTH'(1)
              : cnt_q;
    end
    always_comb begin
        capture     = (state_q == PRESS_WAIT) && (state_d == HELD);
        busy        = (state_q != IDLE);
        load_strobe = strobe_q;
        reg_a       = reg_a_q;
        reg_b       = reg_b_q;
        reg_op      = reg_op_q;
    end
endmodule

// File: tb/tb_switch_operand_loader.sv
// tb_switch_operand_loader: scenario tasks with a capture scoreboard, DEBOUNCE_CYCLES=4.
module tb_switch_operand_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [23:0] switches = '0;
    logic        btn_load = 1'b0;
    logic [7:0]  reg_a, reg_b, reg_op;
    logic        load_strobe, busy;
    int          tests = 0;
    int          fails = 0;
    logic [23:0] exp_q[$];

    switch_operand_loader #(.DEBOUNCE_CYCLES(4), .CNT_WIDTH(20)) dut (
        .clk(clk), .rst(rst), .switches(switches), .btn_load(btn_load),
        .reg_a(reg_a), .reg_b(reg_b), .reg_op(reg_op),
        .load_strobe(load_strobe), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual timeout required completion");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every strobe must match the oldest expected capture.
    always @(negedge clk) begin
        if (load_strobe) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL scoreboard_unexpected: strobe with regs %h, required no strobe", {reg_op, reg_b, reg_a});
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                if ({reg_op, reg_b, reg_a} !== e) begin
                    fails++;
                    $display("FAIL scoreboard_capture: got %h, required %h", {reg_op, reg_b, reg_a}, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_release();
        btn_load = 1'b0;
        repeat (12) step();
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL release_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_reset();
        switches = 24'hFFFFFF;
        btn_load = 1'b1;
        #2 rst = 1'b1;
        repeat (3) step();
        tests++;
        if ({reg_op, reg_b, reg_a, load_strobe, busy} !== 26'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %h/%h/%h strobe=%b busy=%b, required all 0",
                     reg_op, reg_b, reg_a, load_strobe, busy);
        end
        exp_q.push_back(24'hFFFFFF);
        rst = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            tests++;
            if (load_strobe !== (i == 7)) begin
                fails++;
                $display("FAIL reset_strobe_edge%0d: strobe=%b, required %b", i, load_strobe, i == 7);
            end
        end
        do_release();
    endtask

    task automatic test_clean_press();
        switches = 24'h3CA55A;
        exp_q.push_back(24'h3CA55A);
        btn_load = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            tests++;
            if (load_strobe !== (i == 7)) begin
                fails++;
                $display("FAIL clean_strobe_edge%0d: strobe=%b, required %b", i, load_strobe, i == 7);
            end
            if (i == 2 || i == 3) begin
                tests++;
                if (busy !== (i == 3)) begin
                    fails++;
                    $display("FAIL clean_busy_edge%0d: busy=%b, required %b", i, busy, i == 3);
                end
            end
        end
        tests++;
        if ({reg_op, reg_b, reg_a} !== 24'h3CA55A) begin
            fails++;
            $display("FAIL clean_hold_regs: got %h, required 3ca55a", {reg_op, reg_b, reg_a});
        end
        do_release();
    endtask

    task automatic test_press_bounce();
        logic [4:0] pat;
        pat = 5'b01011;
        switches = 24'h123456;
        exp_q.push_back(24'h123456);
        for (int i = 1; i <= 25; i++) begin
            btn_load = (i <= 5) ? pat[i-1] : 1'b1;
            step();
            tests++;
            if (load_strobe !== (i == 12)) begin
                fails++;
                $display("FAIL bounce_strobe_edge%0d: strobe=%b, required %b", i, load_strobe, i == 12);
            end
        end
    endtask

    task automatic test_release_bounce();
        logic [3:0] pat;
        pat = 4'b0100;
        for (int i = 1; i <= 14; i++) begin
            btn_load = (i <= 4) ? pat[i-1] : 1'b0;
            step();
            tests++;
            if (busy !== (i < 10) || load_strobe !== 1'b0) begin
                fails++;
                $display("FAIL relbounce_edge%0d: busy=%b strobe=%b, required busy=%b strobe=0",
                         i, busy, load_strobe, i < 10);
            end
        end
        switches = 24'h010203;
        exp_q.push_back(24'h010203);
        btn_load = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            tests++;
            if (load_strobe !== (i == 7)) begin
                fails++;
                $display("FAIL second_press_edge%0d: strobe=%b, required %b", i, load_strobe, i == 7);
            end
        end
    endtask

    task automatic test_switch_change();
        switches = 24'h000000;
        for (int i = 1; i <= 10; i++) begin
            if (i == 6) btn_load = 1'b0;
            step();
        end
        tests++;
        if ({reg_op, reg_b, reg_a} !== 24'h010203) begin
            fails++;
            $display("FAIL swchange_held: got %h, required 010203", {reg_op, reg_b, reg_a});
        end
        repeat (10) step();
        tests++;
        if ({reg_op, reg_b, reg_a} !== 24'h010203 || busy !== 1'b0) begin
            fails++;
            $display("FAIL swchange_idle: regs %h busy=%b, required 010203 busy=0", {reg_op, reg_b, reg_a}, busy);
        end
    endtask

    task automatic test_reset_mid();
        switches = 24'hAABBCC;
        btn_load = 1'b1;
        repeat (5) step();
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL midreset_pre_busy: busy=%b, required 1", busy);
        end
        rst = 1'b1;
        #1;
        tests++;
        if ({reg_op, reg_b, reg_a, load_strobe, busy} !== 26'd0) begin
            fails++;
            $display("FAIL midreset_outputs: regs %h strobe=%b busy=%b, required all 0",
                     {reg_op, reg_b, reg_a}, load_strobe, busy);
        end
        btn_load = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step();
            tests++;
            if (load_strobe !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL midreset_after_edge%0d: strobe=%b busy=%b, required 0/0", i, load_strobe, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_press_bounce();
        test_release_bounce();
        test_switch_change();
        test_reset_mid();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d captures outstanding, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
